// File: rtl/draw_sprite_anim.sv
// rtl/draw_sprite_anim.sv - animated sprite overlay on a pipelined video bus
// Optional feature macro: DRAW_SPRITE_TRANSPARENCY_EN (colour-key transparency against ALPHA).
// Video bus layout: {hcount[10:0], vcount[10:0], rgb[11:0]}.
module draw_sprite_anim #(
  parameter int          WIDTH        = 48,
  parameter int          HEIGHT       = 64,
  parameter int          ADDR_WIDTH_X = 6,
  parameter int          ADDR_WIDTH_Y = 6,
  parameter int          FRAME_BITS   = 2,
  parameter int          NUM_FRAMES   = 3,
  parameter int          SCALE_X      = 1,
  parameter int          SCALE_Y      = 1,
  parameter int          ANIM_DIV     = 8,
  parameter int          ROM_LATENCY  = 1,
  parameter logic [11:0] ALPHA        = 12'h000,
  localparam int         BUS_WIDTH    = 33
) (
  input  logic                                         pclk,
  input  logic                                         rst,
  input  logic [BUS_WIDTH:0]                           video_bus_in,
  output logic [BUS_WIDTH:0]                           video_bus_out,
  output logic [FRAME_BITS+ADDR_WIDTH_Y+ADDR_WIDTH_X-1:0] pixel_addr,
  input  logic [11:0]                                  rgb_pixel,
  input  logic [10:0]                                  xpos,
  input  logic [10:0]                                  ypos,
  input  logic                                         flip_h,
  input  logic                                         enable,
  input  logic                                         anim_run,
  output logic [FRAME_BITS-1:0]                        frame_idx
);

  localparam int AW    = FRAME_BITS + ADDR_WIDTH_Y + ADDR_WIDTH_X;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int PIPE  = ROM_LATENCY + 1;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        frame_start;

  assign hcount      = video_bus_in[BUS_WIDTH -: 11];
  assign vcount      = video_bus_in[BUS_WIDTH-11 -: 11];
  assign frame_start = (hcount == 11'd0) && (vcount == 11'd0);

  // Per-frame latched controls and animation state
  logic [10:0]           xpos_q, xpos_d;
  logic [10:0]           ypos_q, ypos_d;
  logic                  flip_q, flip_d;
  logic                  enable_q, enable_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  // New controls take effect on the frame-start pixel itself and hold for the frame
  always_comb begin
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    flip_d   = flip_q;
    enable_d = enable_q;
    div_d    = div_q;
    frame_d  = frame_q;
    if (frame_start) begin
      xpos_d   = xpos;
      ypos_d   = ypos;
      flip_d   = flip_h;
      enable_d = enable;
      if (anim_run) begin
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FRAME_BITS'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // Hit test and ROM address generation (12-bit compares so xpos near 2047 never wraps)
  logic [11:0]             h12, v12, x12, y12;
  logic                    hit;
  logic [10:0]             dx, dy;
  logic [10:0]             col_full, row_full;
  logic [ADDR_WIDTH_X-1:0] col;
  logic [ADDR_WIDTH_Y-1:0] row;
  logic [AW-1:0]           addr_q, addr_d;

  // Combinational sprite hit and scaled/mirrored column and row
  always_comb begin
    h12      = {1'b0, hcount};
    v12      = {1'b0, vcount};
    x12      = {1'b0, xpos_d};
    y12      = {1'b0, ypos_d};
    hit      = enable_d
             && (h12 >= x12) && (h12 < x12 + 12'(WIDTH))
             && (v12 >= y12) && (v12 < y12 + 12'(HEIGHT));
    dx       = hcount - xpos_d;
    dy       = vcount - ypos_d;
    row_full = dy / 11'(SCALE_Y);
    if (flip_d) begin
      col_full = 11'(WIDTH / SCALE_X - 1) - dx / 11'(SCALE_X);
    end else begin
      col_full = dx / 11'(SCALE_X);
    end
    col    = '0;
    row    = '0;
    if (hit) begin
      col = ADDR_WIDTH_X'(col_full);
      row = ADDR_WIDTH_Y'(row_full);
    end
    addr_d = {frame_d, row, col};
  end

  // Bus and hit delay line lining up with the ROM read data
  logic [BUS_WIDTH+1:0] pipe_q [PIPE];

  // Shift {hit, bus} through ROM_LATENCY+1 stages
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {hit, video_bus_in};
      for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Control latches, animation counters and registered ROM address
  always_ff @(posedge pclk) begin
    if (rst) begin
      xpos_q   <= '0;
      ypos_q   <= '0;
      flip_q   <= 1'b0;
      enable_q <= 1'b0;
      div_q    <= '0;
      frame_q  <= '0;
      addr_q   <= '0;
    end else begin
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      flip_q   <= flip_d;
      enable_q <= enable_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      addr_q   <= addr_d;
    end
  end

  // Merge stage: sprite pixel replaces background where the aligned hit is set
  logic                 aligned_hit;
  logic [BUS_WIDTH:0]   aligned_bus;
  logic [11:0]          rgb_d;
  logic [BUS_WIDTH:0]   out_q, out_d;

  assign aligned_hit = pipe_q[PIPE-1][BUS_WIDTH+1];
  assign aligned_bus = pipe_q[PIPE-1][BUS_WIDTH:0];

  // Select output colour for the aligned pixel
  always_comb begin
    rgb_d = aligned_bus[11:0];
    if (aligned_hit) begin
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
      if (rgb_pixel != ALPHA) rgb_d = rgb_pixel;
`else
      rgb_d = rgb_pixel;
`endif
    end
    out_d = {aligned_bus[BUS_WIDTH:12], rgb_d};
  end

  // Output register
  always_ff @(posedge pclk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign video_bus_out = out_q;
  assign pixel_addr    = addr_q;
  assign frame_idx     = frame_q;

endmodule

// File: tb/tb_draw_sprite_anim.sv
// tb/tb_draw_sprite_anim.sv - directed self-checking bench for draw_sprite_anim
module tb_draw_sprite_anim;

  localparam logic [33:0] IDLE = {11'd2047, 11'd2047, 12'h000};
`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  localparam logic [11:0] TRANS_EXP = 12'hABC;
`else
  localparam logic [11:0] TRANS_EXP = 12'h000;
`endif

  logic        pclk = 1'b0;
  logic        rst;
  logic [33:0] video_bus_in;
  logic [33:0] video_bus_out;
  logic [13:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic [10:0] xpos, ypos;
  logic        flip_h, enable, anim_run;
  logic [1:0]  frame_idx;
  logic        rom_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  draw_sprite_anim dut (
    .pclk          (pclk),
    .rst           (rst),
    .video_bus_in  (video_bus_in),
    .video_bus_out (video_bus_out),
    .pixel_addr    (pixel_addr),
    .rgb_pixel     (rgb_pixel),
    .xpos          (xpos),
    .ypos          (ypos),
    .flip_h        (flip_h),
    .enable        (enable),
    .anim_run      (anim_run),
    .frame_idx     (frame_idx)
  );

  // Sprite ROM with one cycle of read latency
  function automatic logic [11:0] rom_f(input logic [13:0] a);
    return a[11:0] ^ {a[13:12], 10'd0} ^ 12'h001;
  endfunction

  always @(posedge pclk) rgb_pixel <= rom_zero ? 12'h000 : rom_f(pixel_addr);

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pixel, check its ROM address next cycle and the merged bus two cycles later
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic [11:0] bg, input logic [13:0] ea, input logic [11:0] er);
    video_bus_in = {h, v, bg};
    @(posedge pclk); #1;
    video_bus_in = IDLE;
    chk({tag, ".addr"}, 34'(pixel_addr), 34'(ea));
    repeat (2) @(posedge pclk);
    #1;
    chk({tag, ".bus"}, video_bus_out, {h, v, er});
  endtask

  task automatic fs();
    video_bus_in = 34'd0;
    @(posedge pclk); #1;
    video_bus_in = IDLE;
  endtask

  initial begin
    rst = 1'b1; video_bus_in = IDLE; xpos = 11'd0; ypos = 11'd0;
    flip_h = 1'b0; enable = 1'b0; anim_run = 1'b0; rom_zero = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst.bus", video_bus_out, 34'd0);
    chk("rst.addr", 34'(pixel_addr), 34'd0);
    chk("rst.frame", 34'(frame_idx), 34'd0);
    rst = 1'b0;

    // Basic placement at (100,50)
    xpos = 11'd100; ypos = 11'd50; enable = 1'b1;
    pix("fs0",      11'd0,   11'd0,   12'h123, 14'h0000, 12'h123);
    pix("first",    11'd100, 11'd50,  12'h111, 14'h0000, 12'h001);
    pix("left",     11'd99,  11'd50,  12'h111, 14'h0000, 12'h111);
    pix("right",    11'd147, 11'd50,  12'h222, 14'h002F, 12'h02E);
    pix("rpast",    11'd148, 11'd50,  12'h222, 14'h0000, 12'h222);
    pix("bottom",   11'd100, 11'd113, 12'h333, 14'h0FC0, 12'hFC1);
    pix("bpast",    11'd100, 11'd114, 12'h333, 14'h0000, 12'h333);
    pix("mid",      11'd110, 11'd60,  12'h444, 14'h028A, 12'h28B);

    // Mid-frame xpos change only lands at next frame start
    xpos = 11'd300;
    pix("old_pos",  11'd100, 11'd50,  12'h555, 14'h0000, 12'h001);
    pix("new_early",11'd300, 11'd50,  12'h555, 14'h0000, 12'h555);
    pix("fs1",      11'd0,   11'd0,   12'h666, 14'h0000, 12'h666);
    pix("new_pos",  11'd300, 11'd50,  12'h555, 14'h0000, 12'h001);
    pix("old_gone", 11'd100, 11'd50,  12'h555, 14'h0000, 12'h555);

    // Horizontal mirror
    flip_h = 1'b1;
    pix("fs2",      11'd0,   11'd0,   12'h010, 14'h0000, 12'h010);
    pix("flip_l",   11'd300, 11'd50,  12'h100, 14'h002F, 12'h02E);
    pix("flip_r",   11'd347, 11'd50,  12'h100, 14'h0000, 12'h001);
    flip_h = 1'b0;

    // Colour key (flip still latched for this frame)
    rom_zero = 1'b1;
    pix("alpha",    11'd310, 11'd50,  12'hABC, 14'h0025, TRANS_EXP);
    rom_zero = 1'b0;

    // Disabled sprite
    enable = 1'b0;
    pix("fs3",      11'd0,   11'd0,   12'h010, 14'h0000, 12'h010);
    pix("disabled", 11'd300, 11'd50,  12'h456, 14'h0000, 12'h456);
    enable = 1'b1;
    pix("fs4",      11'd0,   11'd0,   12'h010, 14'h0000, 12'h010);

    // Animation sequencing
    anim_run = 1'b1;
    repeat (7) fs();
    chk("anim7", 34'(frame_idx), 34'd0);
    fs();
    chk("anim8", 34'(frame_idx), 34'd1);
    repeat (4) fs();
    chk("anim12", 34'(frame_idx), 34'd1);
    anim_run = 1'b0;
    repeat (5) fs();
    chk("anim_hold", 34'(frame_idx), 34'd1);
    anim_run = 1'b1;
    repeat (4) fs();
    chk("anim16", 34'(frame_idx), 34'd2);
    pix("frame2",   11'd300, 11'd50,  12'h0F0, 14'h2000, 12'h801);
    repeat (8) fs();
    chk("anim24", 34'(frame_idx), 34'd0);
    repeat (8) fs();
    chk("anim32", 34'(frame_idx), 34'd1);
    anim_run = 1'b0;

    // Reset mid-frame with sprite near the right edge
    xpos = 11'd2040; ypos = 11'd0;
    fs();
    pix("edge",     11'd2045, 11'd5,  12'h0F0, 14'h1145, 12'h544);
    video_bus_in = {11'd2045, 11'd5, 12'h0F0};
    rst = 1'b1;
    @(posedge pclk); #1;
    chk("mrst.bus", video_bus_out, 34'd0);
    chk("mrst.addr", 34'(pixel_addr), 34'd0);
    chk("mrst.frame", 34'(frame_idx), 34'd0);
    @(posedge pclk); #1;
    rst = 1'b0;
    video_bus_in = IDLE;
    pix("blank",    11'd2045, 11'd5,  12'h777, 14'h0000, 12'h777);
    fs();
    chk("post.frame", 34'(frame_idx), 34'd0);
    pix("nowrap",   11'd3,    11'd5,  12'h321, 14'h0000, 12'h321);
    pix("edge_tl",  11'd2040, 11'd0,  12'h321, 14'h0000, 12'h001);
    pix("edge_br",  11'd2047, 11'd63, 12'h321, 14'h0FC7, 12'hFC6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_sprite_anim.md
DRAW_SPRITE_ANIM -- requirements
Module: draw_sprite_anim

Interface
REQ-001 Parameter WIDTH, default 48, on-screen sprite width in pixels after scaling.
REQ-002 Parameter HEIGHT, default 64, on-screen sprite height in pixels after scaling.
REQ-003 Parameter ADDR_WIDTH_X, default 6, ROM column address bits.
REQ-004 Parameter ADDR_WIDTH_Y, default 6, ROM row address bits.
REQ-005 Parameter FRAME_BITS, default 2, ROM frame-select address bits.
REQ-006 Parameter NUM_FRAMES, default 3, animation frames used, 1..2**FRAME_BITS.
REQ-007 Parameter SCALE_X / SCALE_Y, default 1 / 1, integer pixel replication factors.
REQ-008 Parameter ANIM_DIV, default 8, video frames per animation step, >=1.
REQ-009 Parameter ROM_LATENCY, default 1, cycles from pixel_addr to valid rgb_pixel.
REQ-010 Parameter ALPHA, default 12'h000, transparent colour key.
REQ-011 pclk  in  1  pixel clock; all logic on its rising edge.
REQ-012 rst  in  1  reset, synchronous, active-high.
REQ-013 video_bus_in  in  BUS_WIDTH+1  upstream video bus (hcount, vcount, rgb).
REQ-014 video_bus_out  out  BUS_WIDTH+1  downstream video bus with sprite merged.
REQ-015 pixel_addr  out  FRAME_BITS+ADDR_WIDTH_Y+ADDR_WIDTH_X  ROM address {frame, row, col}.
REQ-016 rgb_pixel  in  12  ROM data.
REQ-017 xpos, ypos  in  11 each  sprite top-left corner.
REQ-018 flip_h  in  1  mirror horizontally.
REQ-019 enable  in  1  draw sprite.
REQ-020 anim_run  in  1  advance animation.
REQ-021 frame_idx  out  FRAME_BITS  current animation frame.

Function
REQ-022 xpos, ypos, flip_h and enable SHALL be sampled only on the cycle the input bus shows hcount=0, vcount=0; one sprite position per video frame, no tearing.
REQ-023 Hit SHALL be xpos<=hcount<xpos+WIDTH and ypos<=vcount<ypos+HEIGHT, compared at 12 bits so no wrap near 2047, gated by latched enable.
REQ-024 col = (hcount-xpos)/SCALE_X; with flip_h, col = (WIDTH/SCALE_X-1)-(hcount-xpos)/SCALE_X; row = (vcount-ypos)/SCALE_Y; on miss row=col=0.
REQ-025 pixel_addr SHALL be registered: one cycle after input bus sample.
REQ-026 Hit flag and input bus SHALL be delayed ROM_LATENCY+1 cycles to align with rgb_pixel; output register adds one cycle; total video_bus_in to video_bus_out latency = ROM_LATENCY+2 for every field.
REQ-027 On aligned hit, output rgb = rgb_pixel (subject to REQ-034); on miss, delayed input rgb unchanged.
REQ-028 Animation divider SHALL increment at each frame start while anim_run=1; on reaching ANIM_DIV-1 it clears and frame_idx increments.
REQ-029 frame_idx SHALL wrap NUM_FRAMES-1 -> 0; with NUM_FRAMES=1 it stays 0.
REQ-030 anim_run=0 SHALL freeze divider and frame_idx (no clear).
REQ-031 frame_idx SHALL update only at frame start; pixel_addr frame field uses the value latched at that frame start.

Reset
REQ-032 While rst=1: video_bus_out, pixel_addr, frame_idx, divider, latched xpos/ypos/flip_h/enable and delay pipeline SHALL be 0 at next edge.
REQ-033 Reset mid-line SHALL blank sprite until next frame start (latched enable=0); output bus valid again ROM_LATENCY+2 cycles after rst falls.

Configuration
REQ-034 Macro DRAW_SPRITE_TRANSPARENCY_EN defined: hit pixels with rgb_pixel==ALPHA pass delayed background rgb; undefined: all hit pixels output rgb_pixel, no ALPHA comparator synthesised.

Verification
REQ-035 xpos=100, ypos=50, defaults, enable=1: first sprite pixel at output hcount=100, vcount=50; pixel_addr col 0 row 0; latency 3 cycles.
REQ-036 flip_h=1, WIDTH=48, SCALE_X=1: hcount=xpos -> col 47; hcount=xpos+47 -> col 0.
REQ-037 ANIM_DIV=8, NUM_FRAMES=3, anim_run=1: frame_idx 0->1 after 8 frames, 2->0 after 24; anim_run=0 at 12 holds frame_idx=1.
REQ-038 DRAW_SPRITE_TRANSPARENCY_EN defined, rgb_pixel=12'h000, background 12'hABC: output 12'hABC; undefined: output 12'h000.
REQ-039 xpos changed mid-frame from 100 to 300: current frame still draws at 100, next at 300.
REQ-040 rst pulsed mid-frame with xpos=2040: all outputs 0, no sprite until next frame start, no wrap hit at hcount<8.
